// File: rtl/wb_interconnect_nx1.sv
// wb_interconnect_nx1
// N-master, single-slave Wishbone interconnect.
// - Registered round-robin arbiter. The owner keeps the bus for as long as it holds CYC.
// - Accesses outside [SLAVE0_ADDR_BASE, SLAVE0_ADDR_LIMIT] go to a local error target
//   and are never forwarded to the slave.
// - Optional slave-response watchdog, compiled in when the macro WB_IC_TIMEOUT_EN is defined.
module wb_interconnect_nx1 #(
  parameter int                       N_MASTERS         = 3,
  parameter int                       WB_ADDR_WIDTH     = 32,
  parameter int                       WB_DATA_WIDTH     = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_BASE  = 'h0,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_LIMIT = 'hFFFF_FFFF,
  parameter int                       TIMEOUT_CYCLES    = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
  input  logic [N_MASTERS*3-1:0]                 m_cti,
  input  logic [N_MASTERS*2-1:0]                 m_bte,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
  input  logic [N_MASTERS-1:0]                   m_cyc,
  input  logic [N_MASTERS-1:0]                   m_stb,
  input  logic [N_MASTERS-1:0]                   m_we,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_r,
  output logic [N_MASTERS-1:0]                   m_ack,
  output logic [N_MASTERS-1:0]                   m_err,
  output logic [WB_ADDR_WIDTH-1:0]               s0_adr,
  output logic [WB_DATA_WIDTH-1:0]               s0_dat_w,
  output logic [2:0]                             s0_cti,
  output logic [1:0]                             s0_bte,
  output logic [WB_DATA_WIDTH/8-1:0]             s0_sel,
  output logic                                   s0_cyc,
  output logic                                   s0_stb,
  output logic                                   s0_we,
  input  logic [WB_DATA_WIDTH-1:0]               s0_dat_r,
  input  logic                                   s0_ack,
  input  logic                                   s0_err,
  output logic                                   gnt_valid,
  output logic [$clog2(N_MASTERS)-1:0]           gnt_id
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int GW = $clog2(N_MASTERS);

  // Reject unsupported configurations at elaboration time.
  if (N_MASTERS < 2 || N_MASTERS > 16 || (WB_DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2)
  begin : g_bad_params
    $error("wb_interconnect_nx1: unsupported parameter set");
  end

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_gnt_id, w_gnt_nxt;
  logic [GW-1:0]   r_last_gnt, w_last_nxt;
  logic            r_derr;

  logic            w_mcyc, w_mstb, w_mwe;
  logic [AW-1:0]   w_madr;
  logic [DW-1:0]   w_mdat;
  logic [2:0]      w_mcti;
  logic [1:0]      w_mbte;
  logic [SW-1:0]   w_msel;
  logic            w_own_cyc, w_own_stb;
  logic            w_ge_base, w_le_limit, w_in_window;
  logic            w_fwd, w_derr;
  logic            w_to_err, w_to_lock, w_resp_mask;

  // Pick the first requester strictly above 'last', wrapping around. 'last' itself is
  // the furthest candidate, so it wins only when it is the sole requester.
  function automatic logic [GW-1:0] f_rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [GW-1:0]        last);
    logic [GW-1:0] pick;
    int            best_d;
    int            d;
    pick   = '0;
    best_d = N_MASTERS;
    for (int j = 0; j < N_MASTERS; j++) begin
      d = (j + 2 * N_MASTERS - int'(last) - 1) % N_MASTERS;
      if (req[j] && d < best_d) begin
        best_d = d;
        pick   = GW'(j);
      end
    end
    return pick;
  endfunction

  // Arbiter state, current grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_last_gnt <= GW'(N_MASTERS - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_last_gnt <= w_last_nxt;
    end
  end

  // Next-state logic: grant from IDLE, or re-arbitrate on the edge where the owner
  // releases CYC, so that ownership can pass with no IDLE cycle in between.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_id;
    w_last_nxt  = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (|m_cyc) begin
          w_state_nxt = ST_OWNED;
          w_gnt_nxt   = f_rr_pick(m_cyc, r_last_gnt);
          w_last_nxt  = w_gnt_nxt;
        end
      end
      ST_OWNED: begin
        // The releasing master has CYC low, so it is already out of m_cyc.
        if (!w_mcyc) begin
          if (|m_cyc) begin
            w_gnt_nxt  = f_rr_pick(m_cyc, r_gnt_id);
            w_last_nxt = w_gnt_nxt;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the current owner's request signals.
  always_comb begin
    w_mcyc = 1'b0;
    w_mstb = 1'b0;
    w_mwe  = 1'b0;
    w_madr = '0;
    w_mdat = '0;
    w_mcti = '0;
    w_mbte = '0;
    w_msel = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_gnt_id == GW'(i)) begin
        w_mcyc = m_cyc[i];
        w_mstb = m_stb[i];
        w_mwe  = m_we[i];
        w_madr = m_adr[i*AW +: AW];
        w_mdat = m_dat_w[i*DW +: DW];
        w_mcti = m_cti[i*3 +: 3];
        w_mbte = m_bte[i*2 +: 2];
        w_msel = m_sel[i*SW +: SW];
      end
    end
  end

  assign gnt_valid = (r_state == ST_OWNED);
  assign gnt_id    = r_gnt_id;
  assign w_own_cyc = gnt_valid & w_mcyc;
  assign w_own_stb = w_own_cyc & w_mstb;

  // Window bounds at the edge of the address space are always satisfied.
  if (SLAVE0_ADDR_BASE == '0) begin : g_base_open
    assign w_ge_base = 1'b1;
  end else begin : g_base_cmp
    assign w_ge_base = (w_madr >= SLAVE0_ADDR_BASE);
  end

  if (SLAVE0_ADDR_LIMIT == '1) begin : g_limit_open
    assign w_le_limit = 1'b1;
  end else begin : g_limit_cmp
    assign w_le_limit = (w_madr <= SLAVE0_ADDR_LIMIT);
  end

  assign w_in_window = w_ge_base & w_le_limit;
  assign w_fwd       = w_own_cyc & w_in_window & ~w_to_lock;

  assign s0_cyc   = w_fwd;
  assign s0_stb   = w_fwd & w_mstb;
  assign s0_we    = w_fwd & w_mwe;
  assign s0_adr   = w_fwd ? w_madr : '0;
  assign s0_dat_w = w_fwd ? w_mdat : '0;
  assign s0_cti   = w_fwd ? w_mcti : '0;
  assign s0_bte   = w_fwd ? w_mbte : '0;
  assign s0_sel   = w_fwd ? w_msel : '0;

  // Decode-fail target: answer one cycle after sampling an out-of-window strobe, then
  // stay quiet for one cycle so that each held beat gets its own single-cycle ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_derr <= 1'b0;
    end else begin
      r_derr <= w_own_stb & ~w_in_window & ~r_derr;
    end
  end

  assign w_derr = r_derr & w_own_stb & ~w_in_window;

`ifdef WB_IC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_to_err;
  logic            r_to_lock;

  // Watchdog: count stalled slave cycles, raise one ERR cycle, then detach the slave
  // until the owner ends its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_to_err  <= 1'b0;
      r_to_lock <= 1'b0;
    end else begin
      r_to_err <= 1'b0;
      if (!w_own_cyc) begin
        r_wd_cnt  <= '0;
        r_to_lock <= 1'b0;
      end else if (r_to_err) begin
        r_wd_cnt  <= '0;
        r_to_lock <= 1'b1;
      end else if (s0_cyc && s0_stb && !(s0_ack || s0_err)) begin
        if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          r_wd_cnt <= '0;
          r_to_err <= 1'b1;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign w_to_err  = r_to_err & w_own_cyc;
  assign w_to_lock = r_to_lock;
`else
  assign w_to_err  = 1'b0;
  assign w_to_lock = 1'b0;
`endif

  assign w_resp_mask = w_to_lock | w_to_err;

  // Route terminations and read data to the owner only; all other slices stay 0.
  always_comb begin
    m_ack   = '0;
    m_err   = '0;
    m_dat_r = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_own_cyc && r_gnt_id == GW'(i)) begin
        m_ack[i]            = w_fwd & s0_ack & ~w_resp_mask;
        m_err[i]            = (w_fwd & s0_err & ~w_resp_mask) | w_derr | w_to_err;
        m_dat_r[i*DW +: DW] = (w_fwd & ~w_resp_mask) ? s0_dat_r : '0;
      end
    end
  end

endmodule
